// File: rtl/trace_capture_unit.sv
// Execution-trace recorder for a single-cycle RISC-V core: circular buffer of
// committed {PC, instruction, ALU result}, cycle/retire counters, halt freeze.
module trace_capture_unit #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 16,
  parameter int          CYC_W     = 32,
  parameter logic [31:0] HALT_INST = 32'hFE000EE3,
  parameter bit          HALT_STOP = 1'b1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [31:0]      inst_in,
  input  logic [XLEN-1:0]  alu_in,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_idx,
  output logic             rd_valid,
  output logic [XLEN-1:0]  rd_pc,
  output logic [31:0]      rd_inst,
  output logic [XLEN-1:0]  rd_alu,
  output logic             rd_err,
  output logic             halted,
  output logic [AW:0]      entry_count,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] retired_count
);

  localparam int          ENT_W      = 2 * XLEN + 32;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      entry_count_reg, entry_count_next;
  logic [CYC_W-1:0] cycle_count_reg, cycle_count_next;
  logic [CYC_W-1:0] retired_count_reg, retired_count_next;

  logic             counting;
  logic             capture;
  logic             buf_full;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    rd_slot;
  logic             rd_oob;

  logic [ENT_W-1:0] trace_mem [DEPTH];
  logic [ENT_W-1:0] rd_word_reg;
  logic             rd_valid_reg;
  logic             rd_err_reg;
  logic             rd_zero_reg;

  // With HALT_STOP=0 the HALTED state is only a flag; recording keeps going.
  assign counting = (state_reg == RUN) || (HALT_STOP == 1'b0);
  assign capture  = enable && !clear && counting;
  assign buf_full = (entry_count_reg == FULL_COUNT);
  assign oldest   = buf_full ? wr_ptr_reg : '0;
  assign rd_slot  = oldest + rd_idx;
  assign rd_oob   = ({1'b0, rd_idx} >= entry_count_reg);

  always_comb begin
    state_next         = state_reg;
    wr_ptr_next        = wr_ptr_reg;
    entry_count_next   = entry_count_reg;
    cycle_count_next   = cycle_count_reg;
    retired_count_next = retired_count_reg;
    if (clear) begin
      state_next         = RUN;
      wr_ptr_next        = '0;
      entry_count_next   = '0;
      cycle_count_next   = '0;
      retired_count_next = '0;
    end else begin
      if (state_reg == RUN && enable && inst_in == HALT_INST)
        state_next = HALTED;
      if (counting && cycle_count_reg != '1)
        cycle_count_next = cycle_count_reg + 1'b1;
      if (capture) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (!buf_full)
          entry_count_next = entry_count_reg + 1'b1;
        if (retired_count_reg != '1)
          retired_count_next = retired_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= RUN;
      wr_ptr_reg        <= '0;
      entry_count_reg   <= '0;
      cycle_count_reg   <= '0;
      retired_count_reg <= '0;
    end else begin
      state_reg         <= state_next;
      wr_ptr_reg        <= wr_ptr_next;
      entry_count_reg   <= entry_count_next;
      cycle_count_reg   <= cycle_count_next;
      retired_count_reg <= retired_count_next;
    end
  end

  // Storage and its read register stay reset-free so they map onto block RAM;
  // a same-slot read/write returns the old word (read-first).
  always_ff @(posedge clock) begin
    if (capture)
      trace_mem[wr_ptr_reg] <= {pc_in, inst_in, alu_in};
    if (rd_req)
      rd_word_reg <= trace_mem[rd_slot];
  end

  // rd_zero_reg masks the RAM word after reset and for out-of-range reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_zero_reg  <= 1'b1;
    end else begin
      rd_valid_reg <= rd_req;
      rd_err_reg   <= rd_req && rd_oob;
      if (rd_req)
        rd_zero_reg <= rd_oob;
    end
  end

  assign rd_valid      = rd_valid_reg;
  assign rd_err        = rd_err_reg;
  assign rd_pc         = rd_zero_reg ? '0 : rd_word_reg[ENT_W-1 -: XLEN];
  assign rd_inst       = rd_zero_reg ? '0 : rd_word_reg[XLEN +: 32];
  assign rd_alu        = rd_zero_reg ? '0 : rd_word_reg[XLEN-1:0];
  assign halted        = (state_reg == HALTED);
  assign entry_count   = entry_count_reg;
  assign cycle_count   = cycle_count_reg;
  assign retired_count = retired_count_reg;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed self-checking bench for trace_capture_unit; a second instance with
// HALT_STOP=0 shares the stimulus to show the flag-only halt behaviour.
module tb_trace_capture_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          CYC_W = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] HALT  = 32'hFE000EE3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [XLEN-1:0]  pc_in = '0;
  logic [31:0]      inst_in = '0;
  logic [XLEN-1:0]  alu_in = '0;
  logic             clear = 1'b0;
  logic             rd_req = 1'b0;
  logic [AW-1:0]    rd_idx = '0;

  logic             rd_valid, rd_err, halted;
  logic [XLEN-1:0]  rd_pc, rd_alu;
  logic [31:0]      rd_inst;
  logic [AW:0]      entry_count;
  logic [CYC_W-1:0] cycle_count, retired_count;

  logic             rd_valid2, rd_err2, halted2;
  logic [XLEN-1:0]  rd_pc2, rd_alu2;
  logic [31:0]      rd_inst2;
  logic [AW:0]      entry_count2;
  logic [CYC_W-1:0] cycle_count2, retired_count2;

  int err_cnt = 0;
  int chk_cnt = 0;

  trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W),
                       .HALT_INST(HALT), .HALT_STOP(1'b1)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .pc_in(pc_in),
    .inst_in(inst_in), .alu_in(alu_in), .clear(clear), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
    .rd_alu(rd_alu), .rd_err(rd_err), .halted(halted),
    .entry_count(entry_count), .cycle_count(cycle_count),
    .retired_count(retired_count)
  );

  trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W),
                       .HALT_INST(HALT), .HALT_STOP(1'b0)) u_dut_run (
    .clock(clock), .reset(reset), .enable(enable), .pc_in(pc_in),
    .inst_in(inst_in), .alu_in(alu_in), .clear(clear), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_valid(rd_valid2), .rd_pc(rd_pc2), .rd_inst(rd_inst2),
    .rd_alu(rd_alu2), .rd_err(rd_err2), .halted(halted2),
    .entry_count(entry_count2), .cycle_count(cycle_count2),
    .retired_count(retired_count2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] addi(input int k);
    return 32'h0000_0093 | (32'(k & 12'hFFF) << 20);
  endfunction

  task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu);
    enable  = 1'b1;
    pc_in   = pc;
    inst_in = inst;
    alu_in  = alu;
    tick();
    enable  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic err,
                          input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu);
    rd_req = 1'b1;
    rd_idx = AW'(idx);
    tick();
    rd_req = 1'b0;
    check({tag, ".valid"}, 64'(rd_valid), 64'd1);
    check({tag, ".err"},   64'(rd_err),   64'(err));
    check({tag, ".pc"},    64'(rd_pc),    64'(pc));
    check({tag, ".inst"},  64'(rd_inst),  64'(inst));
    check({tag, ".alu"},   64'(rd_alu),   64'(alu));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst.rd_valid", 64'(rd_valid), 64'd0);
    check("rst.rd_pc", 64'(rd_pc), 64'd0);
    check("rst.halted", 64'(halted), 64'd0);
    check("rst.entry_count", 64'(entry_count), 64'd0);
    check("rst.cycle_count", 64'(cycle_count), 64'd0);
    check("rst.retired_count", 64'(retired_count), 64'd0);
    reset = 1'b0;

    // T1: five commits, read back in order
    for (int k = 0; k < 5; k++) commit(32'(4 * k), addi(k), 32'(100 + k));
    check("t1.entry_count", 64'(entry_count), 64'd5);
    check("t1.retired_count", 64'(retired_count), 64'd5);
    check("t1.cycle_count", 64'(cycle_count), 64'd5);
    for (int k = 0; k < 5; k++)
      read_chk($sformatf("t1.rd%0d", k), k, 1'b0, 32'(4 * k), addi(k), 32'(100 + k));
    tick();
    check("t1.idle_valid", 64'(rd_valid), 64'd0);
    check("t1.idle_hold_pc", 64'(rd_pc), 64'h10);

    // T5a: out-of-range read with three entries
    do_clear();
    check("t5.clr_entry_count", 64'(entry_count), 64'd0);
    for (int k = 0; k < 3; k++) commit(32'(32'h200 + 4 * k), addi(k + 7), 32'(k));
    read_chk("t5.rd7", 7, 1'b1, 32'd0, 32'd0, 32'd0);
    read_chk("t5.rd2", 2, 1'b0, 32'h208, addi(9), 32'd2);

    // T2: overflow of a 16-entry buffer
    do_clear();
    for (int k = 0; k < 20; k++) commit(32'(4 * k), addi(k), 32'(k));
    check("t2.entry_count", 64'(entry_count), 64'd16);
    check("t2.retired_count", 64'(retired_count), 64'd20);
    check("t2.cycle_count", 64'(cycle_count), 64'd20);
    read_chk("t2.rd0", 0, 1'b0, 32'h10, addi(4), 32'd4);
    read_chk("t2.rd15", 15, 1'b0, 32'h4C, addi(19), 32'd19);

    // T5b: read oldest slot while it is being overwritten
    rd_req = 1'b1; rd_idx = '0;
    enable = 1'b1; pc_in = 32'h50; inst_in = addi(20); alu_in = 32'd20;
    tick();
    rd_req = 1'b0; enable = 1'b0;
    check("t5.rw_same.pc", 64'(rd_pc), 64'h10);
    check("t5.rw_same.alu", 64'(rd_alu), 64'd4);
    read_chk("t2.rd0_after", 0, 1'b0, 32'h14, addi(5), 32'd5);
    read_chk("t2.rd15_after", 15, 1'b0, 32'h50, addi(20), 32'd20);

    // T3/T4: halt at PC 0x24, then five more commits
    do_clear();
    for (int k = 0; k < 10; k++) commit(32'(4 * k), (k == 9) ? HALT : addi(k), 32'(k));
    for (int k = 10; k < 15; k++) commit(32'(4 * k), addi(k), 32'(k));
    check("t3.halted", 64'(halted), 64'd1);
    check("t3.entry_count", 64'(entry_count), 64'd10);
    check("t3.retired_count", 64'(retired_count), 64'd10);
    check("t3.cycle_count", 64'(cycle_count), 64'd10);
    check("t4.halted", 64'(halted2), 64'd1);
    check("t4.entry_count", 64'(entry_count2), 64'd15);
    check("t4.retired_count", 64'(retired_count2), 64'd15);
    check("t4.cycle_count", 64'(cycle_count2), 64'd15);
    read_chk("t3.rd9", 9, 1'b0, 32'h24, HALT, 32'd9);
    check("t4.rd9_pc", 64'(rd_pc2), 64'h24);
    read_chk("t3.rd10", 10, 1'b1, 32'd0, 32'd0, 32'd0);
    check("t4.rd10_pc", 64'(rd_pc2), 64'h28);
    check("t3.cycle_frozen", 64'(cycle_count), 64'd10);

    // T6: clear + enable + read in one cycle while HALTED
    clear = 1'b1; enable = 1'b1; pc_in = 32'h100; inst_in = addi(1); alu_in = 32'd1;
    rd_req = 1'b1; rd_idx = AW'(9);
    tick();
    clear = 1'b0; enable = 1'b0; rd_req = 1'b0;
    check("t6.preclear_rd_valid", 64'(rd_valid), 64'd1);
    check("t6.preclear_rd_pc", 64'(rd_pc), 64'h24);
    check("t6.halted", 64'(halted), 64'd0);
    check("t6.entry_count", 64'(entry_count), 64'd0);
    check("t6.retired_count", 64'(retired_count), 64'd0);
    check("t6.cycle_count", 64'(cycle_count), 64'd0);
    read_chk("t6.dropped_entry", 0, 1'b1, 32'd0, 32'd0, 32'd0);

    // T6: reset together with a read request
    rd_req = 1'b1; rd_idx = '0; reset = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t6.rst_rd_valid", 64'(rd_valid), 64'd0);
    check("t6.rst_cycle_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    tick();
    check("t6.post_rst_rd_valid", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
